// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onchip_mem_pkg;

   // Default geometry of the 512x16 single-port on-chip memory
   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_BE_W   = 2;

   // Master identifiers, also used as the last_grant / rd_owner encoding
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // IDLE accepts a command; RD is the single wait cycle of a read
   typedef enum logic {
      IDLE = 1'b0,
      RD   = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a sole requester wins, a tie goes to the master that did not win last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the grant with its own accept condition.
module rr_arb2
   import onchip_mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       any_grant
);

   // One-hot grant selection with tie broken away from the previous winner
   always_comb begin
      grant     = 2'b00;
      any_grant = |req;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == M1) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbitrates CPU (m0) and debug (m1) masters onto the single-port on-chip memory and sequences its strobes.
// Latency: commands accepted in the grant cycle; read data + readdatavalid two cycles after acceptance.
// Backpressure: waitrequest high for the loser, with no request, and for both masters during the read wait cycle.
module onchip_mem_arbiter
   import onchip_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int BE_W        = DEF_BE_W,
   parameter bit M0_WRITE_EN = 1'b0
)
(
   input  logic              clk,
   input  logic              reset,
   // CPU master
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic [BE_W-1:0]   m0_byteenable,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   output logic              m0_wr_drop,
   // Debug master
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [BE_W-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   // Memory port
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_debugaccess,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   state_t            state_q, state_d;
   logic              last_grant_q;
   logic              rd_owner_q;
   logic [ADDR_W-1:0] addr_hold_q;
   logic [BE_W-1:0]   be_hold_q;
   logic [DATA_W-1:0] wdata_hold_q;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              any_grant;
   logic              arb_en;
   logic              granted;
   logic              win;
   logic              win_write;
   logic              wr_permit;
   logic [ADDR_W-1:0] win_address;
   logic [BE_W-1:0]   win_byteenable;
   logic [DATA_W-1:0] win_writedata;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   rr_arb2 u_rr_arb2 (
      .req        (req),
      .last_grant (last_grant_q),
      .grant      (grant),
      .any_grant  (any_grant)
   );

   // Winner selection and memory-side command mux; commands are only taken in IDLE and out of reset
   always_comb begin
      arb_en         = (state_q == IDLE) && !reset;
      granted        = any_grant && arb_en;
      win            = grant[1] ? M1 : M0;
      win_write      = (win == M1) ? m1_write : m0_write;
      win_address    = (win == M1) ? m1_address : m0_address;
      win_byteenable = (win == M1) ? m1_byteenable : m0_byteenable;
      win_writedata  = (win == M1) ? m1_writedata : m0_writedata;
      // The ROM image is only writable from the debug path unless CPU writes are enabled
      wr_permit      = (win == M1) || M0_WRITE_EN;
   end

   // Next state and strobes: a granted read parks one cycle in RD, writes stay in IDLE
   always_comb begin
      state_d         = state_q;
      m0_waitrequest  = !(granted && (win == M0));
      m1_waitrequest  = !(granted && (win == M1));
      mem_address     = addr_hold_q;
      mem_byteenable  = be_hold_q;
      mem_writedata   = wdata_hold_q;
      mem_clken       = 1'b0;
      mem_chipselect  = 1'b0;
      mem_write       = 1'b0;
      mem_debugaccess = 1'b0;
      case (state_q)
         IDLE: begin
            if (granted) begin
               mem_address     = win_address;
               mem_byteenable  = win_byteenable;
               mem_writedata   = win_writedata;
               mem_clken       = 1'b1;
               mem_chipselect  = !win_write || wr_permit;
               mem_write       = win_write && wr_permit;
               mem_debugaccess = win_write && wr_permit;
               if (!win_write) begin
                  state_d = RD;
               end
            end
         end
         RD:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state, fairness pointer and read owner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= M1;
         rd_owner_q   <= M0;
      end else begin
         state_q <= state_d;
         if (granted) begin
            last_grant_q <= win;
            if (!win_write) begin
               rd_owner_q <= win;
            end
         end
      end
   end

   // Memory address/data/byteenable hold their last driven value between grants
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_hold_q  <= '0;
         be_hold_q    <= '0;
         wdata_hold_q <= '0;
      end else if (granted) begin
         addr_hold_q  <= win_address;
         be_hold_q    <= win_byteenable;
         wdata_hold_q <= win_writedata;
      end
   end

   // Read return to the owner only, and the dropped-CPU-write pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m0_readdata      <= '0;
         m1_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         m0_wr_drop       <= 1'b0;
      end else begin
         m0_readdatavalid <= (state_q == RD) && (rd_owner_q == M0);
         m1_readdatavalid <= (state_q == RD) && (rd_owner_q == M1);
         if ((state_q == RD) && (rd_owner_q == M0)) begin
            m0_readdata <= mem_readdata;
         end
         if ((state_q == RD) && (rd_owner_q == M1)) begin
            m1_readdata <= mem_readdata;
         end
         m0_wr_drop <= granted && (win == M0) && win_write && !M0_WRITE_EN;
      end
   end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 512x16 on-chip memory: CPU master (m0) and debug/JTAG master (m1).
- Sits between the fabric masters and the memory's chipselect/write/debugaccess/clken port.
- Serialises accesses with round-robin fairness, generates the memory control strobes, and returns read data with an explicit valid pulse.
- Gates CPU writes so the ROM image is writable only from the debug path, unless enabled by parameter.

Parameters:
- ADDR_W, 9, memory word-address width.
- DATA_W, 16, data width.
- BE_W, 2, byte-enable width (DATA_W/8).
- M0_WRITE_EN, 0, 1 = m0 writes reach memory; 0 = m0 writes are accepted and dropped.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_W  m0 word address.
- m0_read  in  1  m0 read request.
- m0_write  in  1  m0 write request.
- m0_writedata  in  DATA_W  m0 write data.
- m0_byteenable  in  BE_W  m0 byte enables.
- m0_waitrequest  out  1  high = m0 command not accepted this cycle.
- m0_readdata  out  DATA_W  m0 read data, registered.
- m0_readdatavalid  out  1  one-cycle pulse, m0_readdata valid.
- m0_wr_drop  out  1  one-cycle pulse, an m0 write was dropped.
- m1_address / m1_read / m1_write / m1_writedata / m1_byteenable / m1_waitrequest / m1_readdata / m1_readdatavalid: same as m0 (no m1_wr_drop).
- mem_address  out  ADDR_W  to memory.
- mem_byteenable  out  BE_W  to memory.
- mem_chipselect  out  1  to memory.
- mem_write  out  1  to memory.
- mem_writedata  out  DATA_W  to memory.
- mem_debugaccess  out  1  to memory; write-permit qualifier.
- mem_clken  out  1  memory clock enable.
- mem_readdata  in  DATA_W  from memory; unregistered output, valid the cycle after the address is captured.

Behaviour:
- Reset values:
  - state IDLE; last_grant = 1, so m0 wins the first tie.
  - All readdata = 0; readdatavalid, wr_drop, mem_chipselect, mem_write, mem_debugaccess, mem_clken = 0.
  - Both waitrequests = 1.
- FSM states: IDLE, RD.
- IDLE:
  - req_x = read_x | write_x.
  - Grant is combinational: sole requester wins; if both request, the master != last_grant wins.
  - Winner's waitrequest = 0 (command accepted this cycle T); loser's waitrequest = 1.
  - With no requests, both waitrequests = 1.
- Grant cycle T, memory drive:
  - mem_address, mem_byteenable, mem_writedata are muxed from the winner.
  - mem_chipselect = 1 and mem_clken = 1.
  - last_grant <= winner.
- Outside the grant cycle: mem_chipselect = mem_clken = mem_write = mem_debugaccess = 0; address/data hold the last value.
- Write (write_x = 1; takes priority if read_x is also high, and that read is ignored):
  - mem_write = 1 and mem_debugaccess = 1 for m1, or for m0 when M0_WRITE_EN = 1.
  - m0 write with M0_WRITE_EN = 0: still accepted, but mem_chipselect = mem_write = 0 and m0_wr_drop pulses in T+1.
  - State stays IDLE, so one write per cycle is possible.
- Read:
  - Next state RD, with rd_owner <= winner.
  - In RD (cycle T+1): both waitrequests = 1; mem_readdata is captured into rd_owner's readdata.
  - Return in T+2: readdatavalid pulses for exactly one cycle; next state IDLE.
  - Read latency is 2 cycles; peak read throughput is one read per 2 cycles.
- readdata holds its value between pulses; the non-owner's readdata is unchanged.
- Reset asserted mid-RD: the pending return is discarded, no readdatavalid pulse, outputs go to reset values.
- All masters must hold their command stable while their waitrequest is high (Avalon rule); the arbiter does not latch unaccepted commands.

Decomposition:
- Shared package onchip_mem_pkg:
  - state enum {IDLE, RD}.
  - master-id constants M0 = 0, M1 = 1.
  - default ADDR_W, DATA_W, BE_W.
- One sub-module rr_arb2: 2-way round-robin grant logic; inputs req[1:0] and last_grant; outputs one-hot grant and an any-grant flag. Purely combinational.
- last_grant register and FSM live in the top level.

Test Plan:
- Reset with both masters idle → both waitrequests 1, all mem strobes 0, readdatavalid 0 for 10 cycles.
- m0 read addr 0x005, memory model returns 0xBEEF → m0_waitrequest 0 in T with mem_address 0x005 and chipselect/clken 1; m0_readdata = 0xBEEF and m0_readdatavalid = 1 in T+2 only.
- m0 and m1 both read continuously from reset → grants at T (m0), T+2 (m1), T+4 (m0), strictly alternating; each master sees one valid pulse per 4 cycles, and no valid pulse goes to the wrong master.
- m1 back-to-back writes 0x1FF/0x1234/BE 2'b01 then 0x000/0xABCD/BE 2'b11 → mem_write = mem_debugaccess = 1 in two consecutive cycles with matching address/data/byteenable; no readdatavalid.
- m0 write 0x010/0x5555 with M0_WRITE_EN = 0 → accepted in one cycle, mem_chipselect = mem_write = 0, m0_wr_drop pulse in T+1; repeat with M0_WRITE_EN = 1 → mem_write = 1, mem_debugaccess = 1, no drop pulse.
- m1 read accepted in T, reset asserted in T+1 → no m1_readdatavalid ever, state IDLE; after reset release an m0 read completes normally with latency 2.
